// File: rtl/jtag_pkg.sv
// IEEE 1149.1 TAP controller shared definitions: state encoding, the
// TMS-ones count that forces Test-Logic-Reset, and the next-state function.
package jtag_pkg;

  localparam int unsigned TAP_STATE_W  = 4;
  localparam int unsigned TLR_TMS_ONES = 5;

  typedef enum logic [TAP_STATE_W-1:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_t;

  // TAP state transition on a TCK rising edge for the sampled TMS value.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = ST_TLR;
    case (s)
      ST_TLR:      n = tms ? ST_TLR    : ST_RTI;
      ST_RTI:      n = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   n = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   n = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:    n = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR:   n = tms ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: n = tms ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   n = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR:   n = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   n = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   n = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:    n = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR:   n = tms ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: n = tms ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   n = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR:   n = tms ? ST_SEL_DR : ST_RTI;
      default:     n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_clock_gate.sv
// Glitch-free TCK gate: the enable is captured on the TCK falling edge so it
// only changes while TCK is low, then ANDed with TCK.
//   tck  - JTAG test clock
//   clr  - asynchronous active-high clear of the latched enable
//   en   - gate enable, sampled on the TCK falling edge
//   gclk - gated clock output
module jtag_clock_gate (
  input  logic tck,
  input  logic clr,
  input  logic en,
  output logic gclk
);

  logic en_q;
  logic en_d;

  always_comb begin
    en_d = en;
  end

  always_ff @(negedge tck or posedge clr) begin
    if (clr) en_q <= 1'b0;
    else     en_q <= en_d;
  end

  assign gclk = tck & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with per-register strobes and gated clocks.
//   tck, trst (async active-high, forces Test-Logic-Reset), tms
//   tl_reset, select, tdo_en, updateDR, updateIR : registered on TCK falling edge
//   captureDR, shiftDR, captureIR, shiftIR        : decodes of the current state
//   clockDR, clockIR                              : gated TCK (capture/shift only)
// Optional: define TAP_STATE_OUT_EN to add tap_state[3:0] (current state).
module tap_controller
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic       tl_reset,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       clockDR,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       updateIR,
  output logic       clockIR,
  output logic       select,
  output logic       tdo_en
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [3:0] tap_state
`endif
);

  tap_state_t               state_q;
  tap_state_t               state_d;
  logic [TAP_STATE_W-1:0]   state_bits;

  logic tl_reset_q,  tl_reset_d;
  logic select_q,    select_d;
  logic tdo_en_q,    tdo_en_d;
  logic update_dr_q, update_dr_d;
  logic update_ir_q, update_ir_d;

  // State register
  always_comb begin
    state_d = tap_next(state_q, tms);
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= ST_TLR;
    else      state_q <= state_d;
  end

  assign state_bits = state_q;

  // Current-state decodes
  assign captureDR = (state_q == ST_CAP_DR);
  assign shiftDR   = (state_q == ST_SH_DR);
  assign captureIR = (state_q == ST_CAP_IR);
  assign shiftIR   = (state_q == ST_SH_IR);

  // Falling-edge outputs, so downstream logic sees them stable around TCK rise
  always_comb begin
    tl_reset_d  = (state_q == ST_TLR);
    select_d    = state_bits[3];
    tdo_en_d    = shiftDR | shiftIR;
    update_dr_d = (state_q == ST_UPD_DR);
    update_ir_d = (state_q == ST_UPD_IR);
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tl_reset_q  <= 1'b1;
      select_q    <= 1'b1;
      tdo_en_q    <= 1'b0;
      update_dr_q <= 1'b0;
      update_ir_q <= 1'b0;
    end else begin
      tl_reset_q  <= tl_reset_d;
      select_q    <= select_d;
      tdo_en_q    <= tdo_en_d;
      update_dr_q <= update_dr_d;
      update_ir_q <= update_ir_d;
    end
  end

  assign tl_reset = tl_reset_q;
  assign select   = select_q;
  assign tdo_en   = tdo_en_q;
  assign updateDR = update_dr_q;
  assign updateIR = update_ir_q;

  // Gated register clocks: one capture pulse, then one pulse per shift cycle
  jtag_clock_gate u_cg_dr (
    .tck  (tck),
    .clr  (trst),
    .en   (captureDR | shiftDR),
    .gclk (clockDR)
  );

  jtag_clock_gate u_cg_ir (
    .tck  (tck),
    .clr  (trst),
    .en   (captureIR | shiftIR),
    .gclk (clockIR)
  );

`ifdef TAP_STATE_OUT_EN
  assign tap_state = state_bits;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: transition table sweep, TLR entry
// by five TMS ones, DR/IR scans with gated-clock edge counting, and trst abort.
module tb_tap_controller;
  import jtag_pkg::*;

  localparam logic [31:0] ID_CODE = 32'h0BA0_0477;

  logic tck, trst, tms;
  logic tl_reset, captureDR, shiftDR, updateDR, clockDR;
  logic captureIR, shiftIR, updateIR, clockIR, select, tdo_en;
  logic [3:0] cur_state;

  int errors = 0;
  int checks = 0;

`ifdef TAP_STATE_OUT_EN
  logic [3:0] tap_state;
`endif

  tap_controller dut (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tl_reset  (tl_reset),
    .captureDR (captureDR),
    .shiftDR   (shiftDR),
    .updateDR  (updateDR),
    .clockDR   (clockDR),
    .captureIR (captureIR),
    .shiftIR   (shiftIR),
    .updateIR  (updateIR),
    .clockIR   (clockIR),
    .select    (select),
    .tdo_en    (tdo_en)
`ifdef TAP_STATE_OUT_EN
    ,
    .tap_state (tap_state)
`endif
  );

`ifdef TAP_STATE_OUT_EN
  assign cur_state = tap_state;
`else
  assign cur_state = dut.state_q;
`endif

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Event monitors and a 32-bit ID register model clocked by clockDR
  int unsigned clk_dr_edges = 0, clk_ir_edges = 0, cap_ir_edges = 0;
  int unsigned upd_dr_cnt = 0, upd_ir_cnt = 0, dr_strobe_cnt = 0, n_shift = 0;
  logic cap_dr_s = 1'b0, sh_dr_s = 1'b0, cap_ir_s = 1'b0;
  logic [31:0] id_reg = '0, shift_out = '0;

  always @(negedge tck) begin
    cap_dr_s = captureDR;
    sh_dr_s  = shiftDR;
    cap_ir_s = captureIR;
    if (captureDR | shiftDR | updateDR) dr_strobe_cnt++;
  end

  always @(posedge clockDR) begin
    clk_dr_edges++;
    if (cap_dr_s) id_reg = ID_CODE;
    else if (sh_dr_s) begin
      shift_out = {id_reg[0], shift_out[31:1]};
      id_reg    = {1'b1, id_reg[31:1]};
      n_shift++;
    end
  end

  always @(posedge clockIR) begin
    clk_ir_edges++;
    if (cap_ir_s) cap_ir_edges++;
  end

  always @(posedge updateDR) upd_dr_cnt++;
  always @(posedge updateIR) upd_ir_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One TCK cycle; returns just after the falling edge
  task automatic step(input logic t);
    tms = t;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic run(input string p);
    for (int i = 0; i < p.len(); i++) step(p[i] == 8'h31);
  endtask

  task automatic goto(input string p);
    trst = 1'b1;
    #1;
    trst = 1'b0;
    run(p);
  endtask

  typedef struct {
    string      path;
    logic [3:0] from;
    logic [3:0] next0;
    logic [3:0] next1;
  } vec_t;

  vec_t vt[16];
  int   nv = 0;

  task automatic add_vec(input string p, input logic [3:0] f, input logic [3:0] n0,
                         input logic [3:0] n1);
    vt[nv].path  = p;
    vt[nv].from  = f;
    vt[nv].next0 = n0;
    vt[nv].next1 = n1;
    nv++;
  endtask

  initial begin
    int unsigned b_dr, b_ir, b_cir, b_udr, b_uir, b_str, b_sh;
    logic [3:0]  exp_n;

    add_vec("",        4'hF, 4'hC, 4'hF);
    add_vec("0",       4'hC, 4'hC, 4'h7);
    add_vec("01",      4'h7, 4'h6, 4'h4);
    add_vec("010",     4'h6, 4'h2, 4'h1);
    add_vec("0100",    4'h2, 4'h2, 4'h1);
    add_vec("0101",    4'h1, 4'h3, 4'h5);
    add_vec("01010",   4'h3, 4'h3, 4'h0);
    add_vec("010101",  4'h0, 4'h2, 4'h5);
    add_vec("01011",   4'h5, 4'hC, 4'h7);
    add_vec("011",     4'h4, 4'hE, 4'hF);
    add_vec("0110",    4'hE, 4'hA, 4'h9);
    add_vec("01100",   4'hA, 4'hA, 4'h9);
    add_vec("01101",   4'h9, 4'hB, 4'hD);
    add_vec("011010",  4'hB, 4'hB, 4'h8);
    add_vec("0110101", 4'h8, 4'hA, 4'hD);
    add_vec("011011",  4'hD, 4'hC, 4'h7);

    // Reset values
    trst = 1'b1;
    tms  = 1'b1;
    #2;
    chk("rst_state",    cur_state, 4'hF);
    chk("rst_tl_reset", tl_reset, 1);
    chk("rst_select",   select, 1);
    chk("rst_tdo_en",   tdo_en, 0);
    chk("rst_clocks",   {clockDR, clockIR}, 0);
    chk("rst_strobes",  {captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR}, 0);
    @(negedge tck);
    #1;
    trst = 1'b0;

    // Transition sweep: every state with tms=0 and tms=1
    for (int v = 0; v < nv; v++) begin
      for (int t = 0; t < 2; t++) begin
        goto(vt[v].path);
        chk($sformatf("reach_%0h", vt[v].from), cur_state, vt[v].from);
        exp_n = (t == 0) ? vt[v].next0 : vt[v].next1;
        step(t[0]);
        chk($sformatf("next_%0h_tms%0d", vt[v].from, t), cur_state, exp_n);
        chk($sformatf("sel_%0h_tms%0d", vt[v].from, t), select, exp_n[3]);
      end
    end

    // Five TMS ones reach TLR from RTI, Pause-IR and Exit2-DR
    goto("0");
    for (int i = 0; i < int'(TLR_TMS_ONES); i++) step(1'b1);
    chk("ones_rti_state", cur_state, 4'hF);
    chk("ones_rti_tlr", tl_reset, 1);
    goto("011010");
    for (int i = 0; i < int'(TLR_TMS_ONES); i++) step(1'b1);
    chk("ones_pir_state", cur_state, 4'hF);
    chk("ones_pir_tlr", tl_reset, 1);
    goto("010101");
    for (int i = 0; i < int'(TLR_TMS_ONES); i++) step(1'b1);
    chk("ones_e2dr_state", cur_state, 4'hF);
    chk("ones_e2dr_tlr", tl_reset, 1);

    // 32-bit ID scan: capture plus 32 shifts, one update
    goto("0");
    b_dr = clk_dr_edges; b_ir = clk_ir_edges; b_udr = upd_dr_cnt; b_sh = n_shift;
    run("100");
    chk("id_shift_state", cur_state, 4'h2);
    chk("id_tdo_en", tdo_en, 1);
    chk("id_select", select, 0);
    for (int i = 0; i < 31; i++) step(1'b0);
    run("11");
    chk("id_upd_pulse", updateDR, 1);
    step(1'b0);
    chk("id_upd_clear", updateDR, 0);
    chk("id_clkdr_edges", clk_dr_edges - b_dr, 33);
    chk("id_shifts", n_shift - b_sh, 32);
    chk("id_code", shift_out, ID_CODE);
    chk("id_upd_count", upd_dr_cnt - b_udr, 1);
    chk("id_clkir_edges", clk_ir_edges - b_ir, 0);

    // Shift, pause, resume: no gated clock while paused or exiting
    goto("0");
    b_dr = clk_dr_edges; b_udr = upd_dr_cnt;
    run("1000001");
    chk("pz_edges_pre", clk_dr_edges - b_dr, 5);
    run("0001");
    chk("pz_state_ex2", cur_state, 4'h0);
    step(1'b0);
    chk("pz_edges_pause", clk_dr_edges - b_dr, 5);
    run("0001");
    run("10");
    chk("pz_edges_total", clk_dr_edges - b_dr, 9);
    chk("pz_upd_count", upd_dr_cnt - b_udr, 1);

    // IR scan
    goto("0");
    b_dr = clk_dr_edges; b_ir = clk_ir_edges; b_cir = cap_ir_edges;
    b_uir = upd_ir_cnt; b_str = dr_strobe_cnt; b_udr = upd_dr_cnt;
    run("1100");
    chk("ir_shift", shiftIR, 1);
    chk("ir_select", select, 1);
    chk("ir_tdo_en", tdo_en, 1);
    run("0011");
    chk("ir_upd_pulse", updateIR, 1);
    step(1'b0);
    chk("ir_cap_edges", cap_ir_edges - b_cir, 1);
    chk("ir_clk_edges", clk_ir_edges - b_ir, 4);
    chk("ir_upd_count", upd_ir_cnt - b_uir, 1);
    chk("ir_dr_strobes", dr_strobe_cnt - b_str, 0);
    chk("ir_dr_clk", clk_dr_edges - b_dr, 0);
    chk("ir_dr_upd", upd_dr_cnt - b_udr, 0);

    // trst while clockDR is high in Shift-DR
    goto("0100");
    run("00");
    b_dr = clk_dr_edges; b_udr = upd_dr_cnt;
    tms = 1'b1;
    @(posedge tck);
    #1;
    chk("abort_clk_high", clockDR, 1);
    trst = 1'b1;
    #1;
    chk("abort_clk_drop", clockDR, 0);
    chk("abort_shift_drop", shiftDR, 0);
    chk("abort_state", cur_state, 4'hF);
    chk("abort_tl_reset", tl_reset, 1);
    chk("abort_tdo_en", tdo_en, 0);
    chk("abort_select", select, 1);
    @(negedge tck);
    #1;
    trst = 1'b0;
    run("11111");
    chk("abort_no_update", upd_dr_cnt - b_udr, 0);
    chk("abort_no_clk", clk_dr_edges - b_dr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine. Sequences every JTAG test data register (device identification, bypass, boundary scan) and the instruction register.
- Decodes TMS on each TCK rising edge.
- Produces the per-register capture, shift and update strobes, plus glitch-free gated clocks (clockDR, clockIR).
- Produces the test-logic reset, the IR/DR TDO path select and the TDO output enable.
- Sits directly behind the chip's JTAG pins, ahead of the instruction decoder and TDO mux.

Parameters:
- None. State encoding is fixed in the package.

Ports:
- tck  input  1  JTAG test clock; the block's only clock.
- trst  input  1  asynchronous, active-high reset; forces Test-Logic-Reset.
- tms  input  1  test mode select, sampled on tck rising edge.
- tl_reset  output  1  test-logic reset to instruction register/decoder, active-high.
- captureDR  output  1  high while state = Capture-DR.
- shiftDR  output  1  high while state = Shift-DR.
- updateDR  output  1  update strobe for selected data register.
- clockDR  output  1  gated tck; pulses in Capture-DR and Shift-DR only.
- captureIR  output  1  high while state = Capture-IR.
- shiftIR  output  1  high while state = Shift-IR.
- updateIR  output  1  update strobe for instruction register.
- clockIR  output  1  gated tck; pulses in Capture-IR and Shift-IR only.
- select  output  1  1 = IR path to TDO, 0 = DR path.
- tdo_en  output  1  TDO driver enable.

Behaviour:
- State encoding (4 bits):
  - Exit2-DR 0x0, Exit1-DR 0x1, Shift-DR 0x2, Pause-DR 0x3
  - Select-IR 0x4, Update-DR 0x5, Capture-DR 0x6, Select-DR 0x7
  - Exit2-IR 0x8, Exit1-IR 0x9, Shift-IR 0xA, Pause-IR 0xB
  - Run-Test/Idle 0xC, Update-IR 0xD, Capture-IR 0xE, Test-Logic-Reset 0xF
- Transitions on posedge tck, listed as tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR column mirrors the DR column.
- trst=1 at any time: state = TLR immediately (asynchronous). Every output is at its TLR value while trst is asserted.
- Reset/TLR output values: tl_reset=1, select=1, tdo_en=0; all strobes and gated clocks 0.
- Five consecutive tms=1 edges reach TLR from any state.
- Combinational state decodes: captureDR, shiftDR, captureIR, shiftIR.
- Registered on negedge tck (TCK falling edge, per 1149.1):
  - tl_reset = (state==TLR)
  - select = state[3]
  - tdo_en = (state==ShDR or ShIR)
  - updateDR = (state==UpdDR); updateIR = (state==UpdIR)
  - The update registers clear asynchronously on trst.
- Gated clocks:
  - enable_dr = (state==CapDR or ShDR), latched while tck low (falling-edge flop).
  - clockDR = tck AND latched enable_dr. clockIR is built the same way.
  - No runt pulse allowed; clockDR stays low through Pause/Exit/Update states.
- A data register therefore sees exactly one capture edge, then one shift edge per tck spent in Shift-DR.
  - Capture-DR→Shift-DR→Exit1 with N cycles in Shift-DR gives N+1 clockDR rising edges.
- trst mid-Shift-DR: clockDR and shiftDR drop with trst; no update strobe follows.

Optional Feature:
- Macro TAP_STATE_OUT_EN.
- Defined: adds output port tap_state[3:0], carrying the current state encoding (reset 0xF), for on-chip debug and bench observation.
- Undefined: the port does not exist; behaviour is otherwise identical.

Decomposition:
- Package jtag_pkg holds:
  - typedef enum logic [3:0] tap_state_t, with the encoding above
  - constant TLR_TMS_ONES = 5
- Sub-module jtag_clock_gate: falling-edge-latched enable AND tck, with async clear.
  - Instantiated twice, for clockDR and clockIR.

Test Plan:
- trst pulse from Shift-DR → state 0xF, tl_reset=1, tdo_en=0, clockDR stays 0.
- From RTI, tms=1,1,1,1,1 → TLR after 5th edge. Repeat from Pause-IR and Exit2-DR with the same result.
- RTI, tms 1,0,0, then 31×0, then 1,1,0 → clockDR shows 33 rising edges. 32-bit ID register shifts out its full code, LSB=1 first. Exactly one updateDR pulse at the falling edge in Update-DR.
- Shift-DR 4 bits, Exit1, Pause (3 cycles), Exit2, Shift 4 bits → no clockDR edges during Pause/Exit. Total of 9 clockDR edges, including capture.
- IR scan RTI 1,1,0,0,0,0,1,1 → select=1, exactly one captureIR-qualified clockIR edge, one updateIR pulse. No DR strobes asserted.
- Sweep all 16 states × tms∈{0,1} → next state matches the transition list (32 checks).
